ysyx_24080006_icache_array: RTL and testbench

Parametrised N-way set-associative instruction-cache storage array for the IF stage. It holds valid/tag/data per way and set, and does a same-cycle hit lookup with write-to-read bypass. It picks the refill victim way (invalid-first, then per-set round-robin), applies `fence.i` invalidation and keeps saturating hit/miss counters. It is the next generation of the direct-mapped icache register file and is instantiated by the icache controller in the IF stage.

---
 rtl/ysyx_24080006_pkg.sv | 22 ++
 rtl/ysyx_24080006_icache_victim.sv | 31 +++
 rtl/ysyx_24080006_icache_array.sv | 101 ++++++++++
 tb/tb_ysyx_24080006_icache_array.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared icache geometry, line types and way-index width helper.
package ysyx_24080006_pkg;
    function automatic int ic_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int IC_WAYS   = 2;
    localparam int IC_WAY_N  = ic_way_w(IC_WAYS);
    localparam int IC_TAG_W  = 26;
    localparam int IC_LINE_W = 32;

    typedef logic [IC_TAG_W-1:0]  ic_tag_t;
    typedef logic [IC_LINE_W-1:0] ic_line_t;

    typedef struct packed {
        logic     valid;
        ic_tag_t  tag;
        ic_line_t data;
    } icache_way_t;

    typedef icache_way_t ic_set_t [IC_WAYS];
endpackage

// File: rtl/ysyx_24080006_icache_victim.sv
// ysyx_24080006_icache_victim: refill way select; tag match, then lowest invalid, then round-robin.
module ysyx_24080006_icache_victim
    import ysyx_24080006_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int TAG_W = 26,
    localparam int WN   = ic_way_w(WAYS)
) (
    input  logic [WAYS-1:0]            valid_i,
    input  logic [WAYS-1:0][TAG_W-1:0] tag_i,
    input  logic [TAG_W-1:0]           wtag_i,
    input  logic [WN-1:0]              rr_i,
    output logic [WN-1:0]              way_o,
    output logic                       use_rr_o
);
    // Descending loops let the lowest matching index win; the tag pass overrides the invalid pass.
    always_comb begin
        way_o    = rr_i;
        use_rr_o = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_i[w]) begin
                way_o    = WN'(w);
                use_rr_o = 1'b0;
            end
        for (int w = WAYS - 1; w >= 0; w--)
            if (valid_i[w] && tag_i[w] == wtag_i) begin
                way_o    = WN'(w);
                use_rr_o = 1'b0;
            end
    end
endmodule

// File: rtl/ysyx_24080006_icache_array.sv
// ysyx_24080006_icache_array: N-way icache storage with bypassed lookup, victim select, fence.i and hit/miss counters.
module ysyx_24080006_icache_array #(
    parameter int IC_WAYS   = 2,
    parameter int IC_N      = 4,
    parameter int IC_TAG_W  = 26,
    parameter int IC_LINE_W = 32,
    parameter int CNT_W     = 32,
    localparam int WN       = ysyx_24080006_pkg::ic_way_w(IC_WAYS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fencei,
    input  logic                 ic_req,
    input  logic [IC_N-1:0]      ic_index,
    input  logic [IC_TAG_W-1:0]  ic_tag,
    output logic                 ic_hit,
    output logic [WN-1:0]        ic_hit_way,
    output logic [IC_LINE_W-1:0] ic_rdata,
    input  logic                 ic_we,
    input  logic [IC_N-1:0]      ic_waddr,
    input  logic [IC_TAG_W-1:0]  ic_wtag,
    input  logic [IC_LINE_W-1:0] ic_wdata,
    output logic [WN-1:0]        ic_victim_way,
    output logic [CNT_W-1:0]     ic_hit_cnt,
    output logic [CNT_W-1:0]     ic_miss_cnt
);
    localparam int SETS = 1 << IC_N;

    logic [IC_WAYS-1:0]                valid_q [SETS];
    logic [IC_WAYS-1:0][IC_TAG_W-1:0]  tag_q   [SETS];
    logic [IC_WAYS-1:0][IC_LINE_W-1:0] data_q  [SETS];
    logic [WN-1:0]                     rr_q    [SETS];
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [WN-1:0]    rr_d;
    logic             use_rr;

    ysyx_24080006_icache_victim #(.WAYS(IC_WAYS), .TAG_W(IC_TAG_W)) u_victim (
        .valid_i  (valid_q[ic_waddr]),
        .tag_i    (tag_q[ic_waddr]),
        .wtag_i   (ic_wtag),
        .rr_i     (rr_q[ic_waddr]),
        .way_o    (ic_victim_way),
        .use_rr_o (use_rr)
    );

    // The way being refilled this cycle is seen with its incoming contents.
    always_comb begin
        ic_hit     = 1'b0;
        ic_hit_way = '0;
        ic_rdata   = '0;
        for (int w = IC_WAYS - 1; w >= 0; w--)
            if (ic_we && ic_waddr == ic_index && ic_victim_way == WN'(w)) begin
                if (ic_wtag == ic_tag) begin
                    ic_hit     = 1'b1;
                    ic_hit_way = WN'(w);
                    ic_rdata   = ic_wdata;
                end
            end else if (valid_q[ic_index][w] && tag_q[ic_index][w] == ic_tag) begin
                ic_hit     = 1'b1;
                ic_hit_way = WN'(w);
                ic_rdata   = data_q[ic_index][w];
            end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q + CNT_W'(ic_req && !fencei && ic_hit && !(&hit_cnt_q));
        miss_cnt_d = miss_cnt_q + CNT_W'(ic_req && !fencei && !ic_hit && !(&miss_cnt_q));
        rr_d       = (rr_q[ic_waddr] == WN'(IC_WAYS - 1)) ? '0 : rr_q[ic_waddr] + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                tag_q[s]   <= '0;
                data_q[s]  <= '0;
                rr_q[s]    <= '0;
            end
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (fencei) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else if (ic_we) begin
                valid_q[ic_waddr][ic_victim_way] <= 1'b1;
                tag_q[ic_waddr][ic_victim_way]   <= ic_wtag;
                data_q[ic_waddr][ic_victim_way]  <= ic_wdata;
                if (use_rr)
                    rr_q[ic_waddr] <= rr_d;
            end
        end
    end

    assign ic_hit_cnt  = hit_cnt_q;
    assign ic_miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_ysyx_24080006_icache_array.sv
// tb_ysyx_24080006_icache_array: directed refill/lookup/fence.i scenarios checked against a behavioural cache model.
module tb_ysyx_24080006_icache_array;
    localparam int WAYS = 2;
    localparam int SETS = 16;

    logic        clk = 0, reset, fencei, req, we;
    logic [3:0]  index, waddr;
    logic [25:0] tag, wtag;
    logic [31:0] wdata;
    logic        hit, hit4;
    logic [0:0]  hit_way, hit_way4, victim, victim4;
    logic [31:0] rdata, rdata4, hit_cnt, miss_cnt;
    logic [3:0]  hit_cnt4, miss_cnt4;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    ysyx_24080006_icache_array dut (
        .clock(clk), .reset(reset), .fencei(fencei), .ic_req(req),
        .ic_index(index), .ic_tag(tag), .ic_hit(hit), .ic_hit_way(hit_way), .ic_rdata(rdata),
        .ic_we(we), .ic_waddr(waddr), .ic_wtag(wtag), .ic_wdata(wdata),
        .ic_victim_way(victim), .ic_hit_cnt(hit_cnt), .ic_miss_cnt(miss_cnt)
    );

    ysyx_24080006_icache_array #(.CNT_W(4)) dut4 (
        .clock(clk), .reset(reset), .fencei(fencei), .ic_req(req),
        .ic_index(index), .ic_tag(tag), .ic_hit(hit4), .ic_hit_way(hit_way4), .ic_rdata(rdata4),
        .ic_we(we), .ic_waddr(waddr), .ic_wtag(wtag), .ic_wdata(wdata),
        .ic_victim_way(victim4), .ic_hit_cnt(hit_cnt4), .ic_miss_cnt(miss_cnt4)
    );

    // Behavioural model state
    bit          mv  [SETS][WAYS];
    logic [25:0] mt  [SETS][WAYS];
    logic [31:0] md  [SETS][WAYS];
    int          mrr [SETS];
    logic [31:0] mhit, mmiss;
    logic [3:0]  mhit4, mmiss4;
    bit          armed = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic mvictim(input int s, input logic [25:0] t, output int way, output bit used);
        way = -1;
        used = 0;
        for (int w = 0; w < WAYS; w++) if (way < 0 && mv[s][w] && mt[s][w] == t) way = w;
        for (int w = 0; w < WAYS; w++) if (way < 0 && !mv[s][w]) way = w;
        if (way < 0) begin
            way = mrr[s];
            used = 1;
        end
    endtask

    task automatic mlook(output bit h, output int way, output logic [31:0] d);
        int vw;
        bit u, ev;
        logic [25:0] et;
        logic [31:0] ed;
        mvictim(int'(waddr), wtag, vw, u);
        h = 0; way = 0; d = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (we && waddr == index && w == vw) begin
                ev = 1; et = wtag; ed = wdata;
            end else begin
                ev = mv[index][w]; et = mt[index][w]; ed = md[index][w];
            end
            if (!h && ev && et == tag) begin
                h = 1; way = w; d = ed;
            end
        end
    endtask

    always @(posedge clk) begin
        bit h, u;
        int w, vw;
        logic [31:0] d;
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                mrr[s] = 0;
                for (int k = 0; k < WAYS; k++) begin
                    mv[s][k] = 0; mt[s][k] = 0; md[s][k] = 0;
                end
            end
            mhit = 0; mmiss = 0; mhit4 = 0; mmiss4 = 0;
            armed = 1;
        end else begin
            mlook(h, w, d);
            if (req && !fencei) begin
                if (h) begin
                    if (mhit != 32'hFFFF_FFFF) mhit = mhit + 1;
                    if (mhit4 != 4'd15) mhit4 = mhit4 + 1;
                end else begin
                    if (mmiss != 32'hFFFF_FFFF) mmiss = mmiss + 1;
                    if (mmiss4 != 4'd15) mmiss4 = mmiss4 + 1;
                end
            end
            if (fencei) begin
                for (int s = 0; s < SETS; s++) begin
                    mrr[s] = 0;
                    for (int k = 0; k < WAYS; k++) mv[s][k] = 0;
                end
            end else if (we) begin
                mvictim(int'(waddr), wtag, vw, u);
                mv[waddr][vw] = 1; mt[waddr][vw] = wtag; md[waddr][vw] = wdata;
                if (u) mrr[waddr] = (mrr[waddr] + 1) % WAYS;
            end
        end
    end

    always @(negedge clk) begin
        bit h, u;
        int w, vw;
        logic [31:0] d;
        if (armed) begin
            mlook(h, w, d);
            mvictim(int'(waddr), wtag, vw, u);
            chk("cmp_hit", hit, h);
            chk("cmp_hit_way", hit_way, w);
            chk("cmp_rdata", rdata, d);
            chk("cmp_victim", victim, vw);
            chk("cmp_hit_cnt", hit_cnt, mhit);
            chk("cmp_miss_cnt", miss_cnt, mmiss);
            chk("cmp_hit4", hit4, h);
            chk("cmp_hit_way4", hit_way4, w);
            chk("cmp_rdata4", rdata4, d);
            chk("cmp_victim4", victim4, vw);
            chk("cmp_hit_cnt4", hit_cnt4, mhit4);
            chk("cmp_miss_cnt4", miss_cnt4, mmiss4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [3:0] s, input logic [25:0] t, input logic [31:0] dat, input logic exp_way);
        waddr = s; wtag = t; wdata = dat; we = 1;
        #1;
        chk("refill_victim", victim, exp_way);
        tick();
        we = 0;
    endtask

    task automatic look(input logic [3:0] s, input logic [25:0] t, input logic eh, input logic ew, input logic [31:0] ed);
        req = 1; index = s; tag = t;
        #1;
        chk("look_hit", hit, eh);
        chk("look_way", hit_way, ew);
        chk("look_rdata", rdata, ed);
        tick();
        req = 0;
    endtask

    initial begin
        reset = 1; fencei = 0; req = 0; we = 0;
        index = 0; tag = 0; waddr = 0; wtag = 0; wdata = 0;
        tick(); tick();
        reset = 0;

        req = 1; index = 3; tag = 26'h5; waddr = 3; wtag = 26'h5;
        #1;
        chk("rst_hit", hit, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_hit_way", hit_way, 0);
        chk("rst_victim", victim, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        tick();
        req = 0;
        #1;
        chk("first_miss_cnt", miss_cnt, 1);

        refill(4'd3, 26'hA, 32'h1000A, 1'b0);
        refill(4'd3, 26'hB, 32'h1000B, 1'b1);
        refill(4'd3, 26'hC, 32'h1000C, 1'b0);
        waddr = 3; wtag = 26'hD;
        #1;
        chk("rr_advanced", victim, 1);
        look(4'd3, 26'hA, 0, 0, 32'h0);
        look(4'd3, 26'hB, 1, 1, 32'h1000B);
        look(4'd3, 26'hC, 1, 0, 32'h1000C);

        waddr = 2; wtag = 26'h7; wdata = 32'hDEADBEEF; we = 1;
        req = 1; index = 2; tag = 26'h7;
        #1;
        chk("bypass_hit", hit, 1);
        chk("bypass_rdata", rdata, 32'hDEADBEEF);
        chk("bypass_way", hit_way, 0);
        tick();
        we = 0; req = 0;

        refill(4'd3, 26'hB, 32'h2222, 1'b1);
        waddr = 3; wtag = 26'hD;
        #1;
        chk("rr_kept", victim, 1);
        look(4'd3, 26'hB, 1, 1, 32'h2222);
        look(4'd3, 26'hC, 1, 0, 32'h1000C);
        refill(4'd3, 26'hD, 32'h1000D, 1'b1);
        refill(4'd3, 26'hE, 32'h1000E, 1'b0);

        fencei = 1; we = 1; waddr = 5; wtag = 26'h9; wdata = 32'h99;
        req = 1; index = 3; tag = 26'hD;
        #1;
        chk("fence_cycle_hit", hit, 1);
        chk("fence_cycle_way", hit_way, 1);
        tick();
        fencei = 0; we = 0; req = 0;
        index = 5; tag = 26'h9;
        #1;
        chk("fence_dropped_write", hit, 0);
        index = 3; tag = 26'hE;
        #1;
        chk("fence_invalidated", hit, 0);
        waddr = 3; wtag = 26'hF;
        #1;
        chk("fence_victim", victim, 0);
        chk("fence_hit_cnt", hit_cnt, 5);
        chk("fence_miss_cnt", miss_cnt, 2);

        refill(4'd1, 26'h1, 32'h1111, 1'b0);
        for (int i = 0; i < 13; i++) look(4'd1, 26'h1, 1, 0, 32'h1111);
        chk("sat_hit_cnt4", hit_cnt4, 15);
        chk("wide_hit_cnt", hit_cnt, 18);
        chk("sat_miss_cnt4", miss_cnt4, 2);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
